// File: rtl/legv8_instruction_decode_if.sv
// Decode-stage bus: fetch/writeback side is the master, the LEGv8 decoder is the slave.
interface legv8_instruction_decode_if #(
    parameter int XLEN = 64
);
    logic [31:0]     instruction;
    logic [XLEN-1:0] PC;
    logic            RegWriteIn;
    logic [4:0]      WriteReg;
    logic [XLEN-1:0] WriteData;
    logic [3:0]      Flags;

    logic            PCSrc;
    logic [XLEN-1:0] BranchAddress;
    logic [XLEN-1:0] ReadData1;
    logic [XLEN-1:0] ReadData2;
    logic [XLEN-1:0] SignExtImm;
    logic            Reg2Loc;
    logic            ALUSrc;
    logic            MemToReg;
    logic            RegWrite;
    logic            MemRead;
    logic            MemWrite;
    logic [3:0]      ALUOp;
    logic            Halt;

    modport master (
        output instruction, PC, RegWriteIn, WriteReg, WriteData, Flags,
        input  PCSrc, BranchAddress, ReadData1, ReadData2, SignExtImm,
               Reg2Loc, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, ALUOp, Halt
    );

    modport slave (
        input  instruction, PC, RegWriteIn, WriteReg, WriteData, Flags,
        output PCSrc, BranchAddress, ReadData1, ReadData2, SignExtImm,
               Reg2Loc, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, ALUOp, Halt
    );
endinterface

// File: rtl/legv8_instruction_decode.sv
// LEGv8 single-cycle decode stage: register file, immediate extender, control decoder, branch resolve.
// Optional B.cond decoding is enabled by defining ID_BCOND_EN.
module legv8_instruction_decode #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32
) (
    input logic clk,
    input logic reset,
    legv8_instruction_decode_if.slave bus
);

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_ORR   = 4'd3,
        ALU_LSL   = 4'd4,
        ALU_LSR   = 4'd5,
        ALU_PASSB = 4'd6
    } aluOp_e;

    typedef enum logic [2:0] {
        BR_NONE,
        BR_B,
        BR_BL,
        BR_CBZ,
        BR_CBNZ,
        BR_REG,
        BR_COND
    } brKind_e;

    logic [31:0]     instr;
    logic [10:0]     op11;
    logic            reg2Loc;
    logic            aluSrc;
    logic            memToReg;
    logic            regWrite;
    logic            memRead;
    logic            memWrite;
    aluOp_e          aluOp;
    logic            halt;
    logic [XLEN-1:0] imm;
    brKind_e         brKind;

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic            extWriteEn;
    logic            linkWriteEn;
    logic [XLEN-1:0] pcPlus4;
    logic [4:0]      rnAddr;
    logic [4:0]      rmAddr;
    logic [XLEN-1:0] readData1;
    logic [XLEN-1:0] readData2;

    logic [XLEN-1:0] uncondOffset;
    logic [XLEN-1:0] condOffset;
    logic            condTrue;
    logic            pcSrc;
    logic [XLEN-1:0] branchAddr;

    assign instr = bus.instruction;
    assign op11  = instr[31:21];

    // Main control decode; HALT is tested first so it shadows every other pattern.
    always_comb begin
        reg2Loc  = 1'b0;
        aluSrc   = 1'b0;
        memToReg = 1'b0;
        regWrite = 1'b0;
        memRead  = 1'b0;
        memWrite = 1'b0;
        aluOp    = ALU_ADD;
        halt     = 1'b0;
        imm      = '0;
        brKind   = BR_NONE;

        if (op11 == 11'h7FF) begin
            halt = 1'b1;
        end else if (op11 == 11'b10001011000) begin
            regWrite = 1'b1;
            aluOp    = ALU_ADD;
        end else if (op11 == 11'b11001011000) begin
            regWrite = 1'b1;
            aluOp    = ALU_SUB;
        end else if (op11 == 11'b10001010000) begin
            regWrite = 1'b1;
            aluOp    = ALU_AND;
        end else if (op11 == 11'b10101010000) begin
            regWrite = 1'b1;
            aluOp    = ALU_ORR;
        end else if (op11 == 11'b11010011011) begin
            regWrite = 1'b1;
            aluSrc   = 1'b1;
            aluOp    = ALU_LSL;
            imm      = {{(XLEN-6){1'b0}}, instr[15:10]};
        end else if (op11 == 11'b11010011010) begin
            regWrite = 1'b1;
            aluSrc   = 1'b1;
            aluOp    = ALU_LSR;
            imm      = {{(XLEN-6){1'b0}}, instr[15:10]};
        end else if (op11 == 11'b11111000010) begin
            regWrite = 1'b1;
            aluSrc   = 1'b1;
            memRead  = 1'b1;
            memToReg = 1'b1;
            aluOp    = ALU_ADD;
            imm      = {{(XLEN-9){instr[20]}}, instr[20:12]};
        end else if (op11 == 11'b11111000000) begin
            reg2Loc  = 1'b1;
            aluSrc   = 1'b1;
            memWrite = 1'b1;
            aluOp    = ALU_ADD;
            imm      = {{(XLEN-9){instr[20]}}, instr[20:12]};
        end else if (op11 == 11'b11010110000) begin
            brKind = BR_REG;
        end else if (instr[31:22] == 10'b1001000100) begin
            regWrite = 1'b1;
            aluSrc   = 1'b1;
            aluOp    = ALU_ADD;
            imm      = {{(XLEN-12){1'b0}}, instr[21:10]};
        end else if (instr[31:22] == 10'b1101000100) begin
            regWrite = 1'b1;
            aluSrc   = 1'b1;
            aluOp    = ALU_SUB;
            imm      = {{(XLEN-12){1'b0}}, instr[21:10]};
        end else if (instr[31:24] == 8'b10110100) begin
            reg2Loc = 1'b1;
            aluOp   = ALU_PASSB;
            brKind  = BR_CBZ;
        end else if (instr[31:24] == 8'b10110101) begin
            reg2Loc = 1'b1;
            aluOp   = ALU_PASSB;
            brKind  = BR_CBNZ;
`ifdef ID_BCOND_EN
        end else if (instr[31:24] == 8'b01010100) begin
            brKind = BR_COND;
`endif
        end else if (instr[31:26] == 6'b000101) begin
            brKind = BR_B;
        end else if (instr[31:26] == 6'b100101) begin
            brKind = BR_BL;
        end
    end

    assign pcPlus4     = bus.PC + XLEN'(4);
    assign extWriteEn  = bus.RegWriteIn && (bus.WriteReg != 5'd31) && !reset;
    assign linkWriteEn = (brKind == BR_BL) && !reset;

    // Next register state; the BL link is applied last so it overrides a same-cycle X30 write.
    always_comb begin
        regs_d = regs_q;
        if (extWriteEn) begin
            regs_d[bus.WriteReg] = bus.WriteData;
        end
        if (linkWriteEn) begin
            regs_d[30] = pcPlus4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Reading from regs_d gives write-first behaviour for free.
    assign rnAddr    = instr[9:5];
    assign rmAddr    = reg2Loc ? instr[4:0] : instr[20:16];
    assign readData1 = (rnAddr == 5'd31) ? '0 : regs_d[rnAddr];
    assign readData2 = (rmAddr == 5'd31) ? '0 : regs_d[rmAddr];

    assign uncondOffset = {{(XLEN-28){instr[25]}}, instr[25:0], 2'b00};
    assign condOffset   = {{(XLEN-21){instr[23]}}, instr[23:5], 2'b00};

`ifdef ID_BCOND_EN
    function automatic logic evalCond(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v, base;
        n = nzcv[3];
        z = nzcv[2];
        c = nzcv[1];
        v = nzcv[0];
        case (cond[3:1])
            3'b000:  base = z;
            3'b001:  base = c;
            3'b010:  base = n;
            3'b011:  base = v;
            3'b100:  base = c && !z;
            3'b101:  base = (n == v);
            3'b110:  base = !z && (n == v);
            default: base = 1'b1;
        endcase
        // Odd codes invert their even partner, except 1111 which is always-true like AL.
        if (cond[0] && (cond != 4'hF)) begin
            base = !base;
        end
        return base;
    endfunction

    assign condTrue = evalCond(instr[3:0], bus.Flags);
`else
    logic unusedFlags;
    assign unusedFlags = ^bus.Flags;
    assign condTrue    = 1'b0;
`endif

    // Branch resolve; the target is shown even when the branch falls through.
    always_comb begin
        pcSrc      = 1'b0;
        branchAddr = '0;
        case (brKind)
            BR_B, BR_BL: begin
                pcSrc      = 1'b1;
                branchAddr = bus.PC + uncondOffset;
            end
            BR_CBZ: begin
                pcSrc      = (readData2 == '0);
                branchAddr = bus.PC + condOffset;
            end
            BR_CBNZ: begin
                pcSrc      = (readData2 != '0);
                branchAddr = bus.PC + condOffset;
            end
            BR_REG: begin
                pcSrc      = 1'b1;
                branchAddr = readData1;
            end
            BR_COND: begin
                pcSrc      = condTrue;
                branchAddr = bus.PC + condOffset;
            end
            default: begin
                pcSrc      = 1'b0;
                branchAddr = '0;
            end
        endcase
    end

    assign bus.PCSrc         = pcSrc && !reset;
    assign bus.BranchAddress = branchAddr;
    assign bus.ReadData1     = readData1;
    assign bus.ReadData2     = readData2;
    assign bus.SignExtImm    = imm;
    assign bus.Reg2Loc       = reg2Loc;
    assign bus.ALUSrc        = aluSrc;
    assign bus.MemToReg      = memToReg;
    assign bus.RegWrite      = regWrite && !reset;
    assign bus.MemRead       = memRead && !reset;
    assign bus.MemWrite      = memWrite && !reset;
    assign bus.ALUOp         = aluOp;
    assign bus.Halt          = halt && !reset;

endmodule

// File: tb/tb_legv8_instruction_decode.sv
// Directed self-checking bench for the LEGv8 decode stage.
module tb_legv8_instruction_decode;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    legv8_instruction_decode_if #(.XLEN(64)) bus ();

    legv8_instruction_decode #(.XLEN(64), .NREGS(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, 10-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Every comparison funnels through here.
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    // Present an instruction mid-cycle and let the combinational decode settle.
    task automatic applyStimulus(input logic [31:0] instr, input logic [63:0] pc);
        @(negedge clk);
        bus.instruction = instr;
        bus.PC          = pc;
        #1;
    endtask

    task automatic writeRegister(input logic [4:0] r, input logic [63:0] d);
        @(negedge clk);
        bus.RegWriteIn = 1'b1;
        bus.WriteReg   = r;
        bus.WriteData  = d;
        @(posedge clk);
        #1;
        bus.RegWriteIn = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        reset           = 1'b1;
        bus.instruction = 32'h1400_0001;
        bus.PC          = 64'h0;
        bus.RegWriteIn  = 1'b0;
        bus.WriteReg    = 5'd0;
        bus.WriteData   = 64'h0;
        bus.Flags       = 4'b0000;
        #2;
        checkOutput("reset_pcsrc", 64'(bus.PCSrc), 64'd0);
        bus.instruction = 32'h8B06_00A1;
        #1;
        checkOutput("reset_regwrite", 64'(bus.RegWrite), 64'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] ADD X1,X5,X6 after reset");
        applyStimulus(32'h8B06_00A1, 64'h0);
        checkOutput("add_rd1", bus.ReadData1, 64'h0);
        checkOutput("add_rd2", bus.ReadData2, 64'h0);
        checkOutput("add_regwrite", 64'(bus.RegWrite), 64'd1);
        checkOutput("add_aluop", 64'(bus.ALUOp), 64'd0);
        checkOutput("add_pcsrc", 64'(bus.PCSrc), 64'd0);
        checkOutput("add_baddr", bus.BranchAddress, 64'h0);

        // Same-cycle write to X6 must bypass to ReadData2, then persist.
        bus.RegWriteIn = 1'b1;
        bus.WriteReg   = 5'd6;
        bus.WriteData  = 64'h1234;
        #1;
        checkOutput("bypass_rd2", bus.ReadData2, 64'h1234);
        @(posedge clk);
        #1;
        bus.RegWriteIn = 1'b0;
        #1;
        checkOutput("stored_rd2", bus.ReadData2, 64'h1234);

        $display("[TB] CBZ/CBNZ on X5");
        writeRegister(5'd5, 64'h10);
        applyStimulus(32'hB400_0065, 64'h20);
        checkOutput("cbz_nz_pcsrc", 64'(bus.PCSrc), 64'd0);
        checkOutput("cbz_baddr", bus.BranchAddress, 64'h2C);
        checkOutput("cbz_rd2", bus.ReadData2, 64'h10);
        checkOutput("cbz_reg2loc", 64'(bus.Reg2Loc), 64'd1);
        checkOutput("cbz_aluop", 64'(bus.ALUOp), 64'd6);
        applyStimulus(32'hB500_0065, 64'h20);
        checkOutput("cbnz_nz_pcsrc", 64'(bus.PCSrc), 64'd1);
        writeRegister(5'd5, 64'h0);
        applyStimulus(32'hB400_0065, 64'h20);
        checkOutput("cbz_z_pcsrc", 64'(bus.PCSrc), 64'd1);
        applyStimulus(32'hB500_0065, 64'h20);
        checkOutput("cbnz_z_pcsrc", 64'(bus.PCSrc), 64'd0);

        $display("[TB] B / BL");
        applyStimulus(32'h17FF_FFFF, 64'h40);
        checkOutput("b_pcsrc", 64'(bus.PCSrc), 64'd1);
        checkOutput("b_baddr", bus.BranchAddress, 64'h3C);
        applyStimulus(32'h9400_0004, 64'h8);
        checkOutput("bl_pcsrc", 64'(bus.PCSrc), 64'd1);
        checkOutput("bl_baddr", bus.BranchAddress, 64'h18);
        // Competing external write to X30 must lose to the link.
        bus.RegWriteIn = 1'b1;
        bus.WriteReg   = 5'd30;
        bus.WriteData  = 64'h999;
        @(posedge clk);
        #1;
        bus.RegWriteIn = 1'b0;
        applyStimulus(32'h8B1F_03C1, 64'h0);
        checkOutput("bl_link_x30", bus.ReadData1, 64'hC);
        checkOutput("xzr_rd2", bus.ReadData2, 64'h0);

        $display("[TB] LDUR / STUR");
        applyStimulus(32'hF85F_8062, 64'h0);
        checkOutput("ldur_memread", 64'(bus.MemRead), 64'd1);
        checkOutput("ldur_memtoreg", 64'(bus.MemToReg), 64'd1);
        checkOutput("ldur_alusrc", 64'(bus.ALUSrc), 64'd1);
        checkOutput("ldur_regwrite", 64'(bus.RegWrite), 64'd1);
        checkOutput("ldur_imm", bus.SignExtImm, 64'hFFFF_FFFF_FFFF_FFF8);
        applyStimulus(32'hF81F_8062, 64'h0);
        checkOutput("stur_memwrite", 64'(bus.MemWrite), 64'd1);
        checkOutput("stur_regwrite", 64'(bus.RegWrite), 64'd0);
        checkOutput("stur_reg2loc", 64'(bus.Reg2Loc), 64'd1);
        checkOutput("stur_memread", 64'(bus.MemRead), 64'd0);

        $display("[TB] XZR and HALT");
        applyStimulus(32'h8B1F_03E1, 64'h0);
        bus.RegWriteIn = 1'b1;
        bus.WriteReg   = 5'd31;
        bus.WriteData  = 64'hDEAD;
        #1;
        checkOutput("xzr_bypass_rd1", bus.ReadData1, 64'h0);
        @(posedge clk);
        #1;
        bus.RegWriteIn = 1'b0;
        #1;
        checkOutput("xzr_stored_rd2", bus.ReadData2, 64'h0);
        applyStimulus(32'hFFE0_0000, 64'h0);
        checkOutput("halt_halt", 64'(bus.Halt), 64'd1);
        checkOutput("halt_pcsrc", 64'(bus.PCSrc), 64'd0);
        checkOutput("halt_regwrite", 64'(bus.RegWrite), 64'd0);

        $display("[TB] ALU ops and immediates");
        applyStimulus(32'hD360_1441, 64'h0);
        checkOutput("lsl_imm", bus.SignExtImm, 64'd5);
        checkOutput("lsl_aluop", 64'(bus.ALUOp), 64'd4);
        checkOutput("lsl_alusrc", 64'(bus.ALUSrc), 64'd1);
        applyStimulus(32'h913F_FC41, 64'h0);
        checkOutput("addi_imm", bus.SignExtImm, 64'hFFF);
        checkOutput("addi_regwrite", 64'(bus.RegWrite), 64'd1);
        applyStimulus(32'hCB06_00A1, 64'h0);
        checkOutput("sub_aluop", 64'(bus.ALUOp), 64'd1);
        applyStimulus(32'h8A06_00A1, 64'h0);
        checkOutput("and_aluop", 64'(bus.ALUOp), 64'd2);
        applyStimulus(32'hAA06_00A1, 64'h0);
        checkOutput("orr_aluop", 64'(bus.ALUOp), 64'd3);

        $display("[TB] BR and unknown");
        writeRegister(5'd3, 64'h1000);
        applyStimulus(32'hD600_0060, 64'h0);
        checkOutput("br_pcsrc", 64'(bus.PCSrc), 64'd1);
        checkOutput("br_baddr", bus.BranchAddress, 64'h1000);
        applyStimulus(32'h0000_0000, 64'h50);
        checkOutput("unk_pcsrc", 64'(bus.PCSrc), 64'd0);
        checkOutput("unk_baddr", bus.BranchAddress, 64'h0);
        checkOutput("unk_regwrite", 64'(bus.RegWrite), 64'd0);

        $display("[TB] B.EQ");
        bus.Flags = 4'b0100;
        applyStimulus(32'h5400_0040, 64'h100);
`ifdef ID_BCOND_EN
        checkOutput("beq_z_pcsrc", 64'(bus.PCSrc), 64'd1);
        checkOutput("beq_baddr", bus.BranchAddress, 64'h108);
`else
        checkOutput("beq_off_pcsrc", 64'(bus.PCSrc), 64'd0);
        checkOutput("beq_off_baddr", bus.BranchAddress, 64'h0);
`endif
        bus.Flags = 4'b0000;
        #1;
        checkOutput("beq_nz_pcsrc", 64'(bus.PCSrc), 64'd0);

        $display("[TB] reset clears over a pending write");
        @(negedge clk);
        bus.instruction = 32'h8B06_00A1;
        bus.RegWriteIn  = 1'b1;
        bus.WriteReg    = 5'd5;
        bus.WriteData   = 64'h55;
        reset           = 1'b1;
        #1;
        checkOutput("rst_regwrite", 64'(bus.RegWrite), 64'd0);
        @(posedge clk);
        #1;
        bus.RegWriteIn = 1'b0;
        reset          = 1'b0;
        applyStimulus(32'h8B06_00A1, 64'h0);
        checkOutput("rst_rd1", bus.ReadData1, 64'h0);
        checkOutput("rst_rd2", bus.ReadData2, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
